// File: rtl/filtro_sensores.sv
// Level-sensor input conditioning: two-flop synchroniser, per-bit debounce,
// and a windowed chatter monitor that flags float switches that toggle too often.
module filtro_sensores #(
  parameter int unsigned DEBOUNCE    = 16,
  parameter int unsigned VENTANA     = 1024,
  parameter int unsigned MAX_CAMBIOS = 8,
  parameter logic [2:0]  SENS_RESET  = 3'b111
) (
  input  logic       ck,
  input  logic       rst_i,
  input  logic [2:0] sensores_raw_i,
  output logic [2:0] sensores_o,
  output logic       cambio_o,
  output logic [2:0] falla_bits_o,
  output logic       falla_o
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TR_W  = $clog2(MAX_CAMBIOS + 1);
  localparam int WIN_W = $clog2(VENTANA);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE - 1);
  localparam logic [TR_W-1:0]  TR_MAX   = TR_W'(MAX_CAMBIOS);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VENTANA - 1);

  logic [2:0]            s1_q, s2_q, s3_q;
  logic [2:0]            filt_q, filt_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0][TR_W-1:0]  tr_q, tr_d, tr_sum;
  logic [WIN_W-1:0]      win_q, win_d;
  logic                  cambio_q, cambio_d;
  logic [2:0]            falla_q, falla_d;
  logic [2:0]            flanco;

  assign flanco = s2_q ^ s3_q;

  always_comb begin
    filt_d  = filt_q;
    cnt_d   = '0;
    tr_d    = tr_q;
    tr_sum  = '0;
    falla_d = falla_q;
    win_d   = (win_q == WIN_LAST) ? '0 : win_q + WIN_W'(1);
    for (int i = 0; i < 3; i++) begin
      // Any cycle where the synchronised level agrees with filt resets progress.
      if (s2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          filt_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
      tr_sum[i] = (tr_q[i] == TR_MAX) ? TR_MAX : tr_q[i] + TR_W'(flanco[i]);
      // An edge on the closing cycle belongs to the window being closed.
      if (win_q == WIN_LAST) begin
        falla_d[i] = (tr_sum[i] >= TR_MAX);
        tr_d[i]    = '0;
      end else begin
        tr_d[i] = tr_sum[i];
      end
    end
    cambio_d = (filt_d != filt_q);
  end

  always_ff @(posedge ck or negedge rst_i) begin
    if (!rst_i) begin
      s1_q     <= SENS_RESET;
      s2_q     <= SENS_RESET;
      s3_q     <= SENS_RESET;
      filt_q   <= SENS_RESET;
      cnt_q    <= '0;
      tr_q     <= '0;
      win_q    <= '0;
      cambio_q <= 1'b0;
      falla_q  <= '0;
    end else begin
      s1_q     <= sensores_raw_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      tr_q     <= tr_d;
      win_q    <= win_d;
      cambio_q <= cambio_d;
      falla_q  <= falla_d;
    end
  end

  assign sensores_o   = filt_q;
  assign cambio_o     = cambio_q;
  assign falla_bits_o = falla_q;
  assign falla_o      = |falla_q;

endmodule

// File: tb/tb_filtro_sensores.sv
// Bench for filtro_sensores: table-driven debounce steps, chatter windows and
// mid-operation reset, with expected update pulses held in a scoreboard queue.
module tb_filtro_sensores;

  localparam int DEB  = 4;
  localparam int VEN  = 32;
  localparam int MAXC = 3;

  logic       ck;
  logic       rst_i;
  logic [2:0] raw;
  logic [2:0] sensores_o;
  logic       cambio_o;
  logic [2:0] falla_bits_o;
  logic       falla_o;

  filtro_sensores #(
    .DEBOUNCE(DEB), .VENTANA(VEN), .MAX_CAMBIOS(MAXC), .SENS_RESET(3'b111)
  ) dut (
    .ck(ck), .rst_i(rst_i), .sensores_raw_i(raw),
    .sensores_o(sensores_o), .cambio_o(cambio_o),
    .falla_bits_o(falla_bits_o), .falla_o(falla_o)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected sensores_o value and the cycle of its cambio_o pulse.
  logic [2:0] exp_q[$];
  int         exp_cyc_q[$];

  // Window model: transitions per window, located by the edge that counts them.
  int         cyc;
  logic [2:0] prev_raw;
  logic [2:0] exp_falla;
  int         win_tr[64][3];

  typedef struct {
    logic [2:0] raw;
    int         hold;
    bit         pulse;
    logic [2:0] exp_end;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic restart_model();
    cyc = 0;
    prev_raw = 3'b111;
    exp_falla = 3'b000;
    exp_q.delete();
    exp_cyc_q.delete();
    for (int w = 0; w < 64; w++)
      for (int b = 0; b < 3; b++) win_tr[w][b] = 0;
  endtask

  task automatic tick();
    int n;
    int w;
    n = cyc + 1;
    for (int b = 0; b < 3; b++) begin
      if (raw[b] != prev_raw[b]) begin
        w = (n + 1) / VEN;
        if (w < 64) win_tr[w][b]++;
      end
    end
    prev_raw = raw;
    @(posedge ck);
    #1;
    cyc = n;
    if (cyc % VEN == 0) begin
      w = cyc / VEN - 1;
      for (int b = 0; b < 3; b++) exp_falla[b] = (win_tr[w][b] >= MAXC);
    end
    check("falla_bits", falla_bits_o, exp_falla);
    check("falla_or", falla_o, |exp_falla);
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      check("pulse", cambio_o, 1);
      check("pulse_sens", sensores_o, exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end else begin
      check("no_pulse", cambio_o, 0);
    end
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push_at(input int c, input logic [2:0] v);
    exp_cyc_q.push_back(c);
    exp_q.push_back(v);
  endtask

  // A level first sampled on the next edge shows up DEB+1 edges after that.
  task automatic drive(input logic [2:0] v);
    raw = v;
    push_at(cyc + DEB + 2, v);
  endtask

  initial begin
    int base;
    tbl[0]  = '{3'b111, 10, 1'b1, 3'b111};
    tbl[1]  = '{3'b011, 10, 1'b1, 3'b011};
    tbl[2]  = '{3'b111, 10, 1'b1, 3'b111};
    tbl[3]  = '{3'b011,  3, 1'b0, 3'b111};
    tbl[4]  = '{3'b111, 10, 1'b0, 3'b111};
    tbl[5]  = '{3'b011,  4, 1'b1, 3'b111};
    tbl[6]  = '{3'b111, 10, 1'b1, 3'b111};
    tbl[7]  = '{3'b001, 10, 1'b1, 3'b001};
    tbl[8]  = '{3'b111, 10, 1'b1, 3'b111};
    tbl[9]  = '{3'b110,  1, 1'b0, 3'b111};
    tbl[10] = '{3'b111,  8, 1'b0, 3'b111};

    restart_model();
    rst_i = 1'b0;
    raw = 3'b000;
    repeat (3) @(posedge ck);
    #1;
    check("rst_sens", sensores_o, 3'b111);
    check("rst_cambio", cambio_o, 0);
    check("rst_falla", falla_o, 0);
    rst_i = 1'b1;
    restart_model();
    push_at(DEB + 2, 3'b000);
    run_to(10);
    check("post_rst_sens", sensores_o, 3'b000);

    for (int k = 0; k < 11; k++) begin
      raw = tbl[k].raw;
      if (tbl[k].pulse) push_at(cyc + DEB + 2, tbl[k].raw);
      repeat (tbl[k].hold) tick();
      check("vec_end_sens", sensores_o, tbl[k].exp_end);
    end

    repeat (70) tick();
    while (cyc % VEN != 0) tick();
    check("chat_pre", falla_o, 0);
    base = cyc;
    for (int t = 0; t < 16; t++) begin
      raw[0] = ~raw[0];
      tick();
      tick();
    end
    check("chat_close_cyc", cyc, base + VEN);
    check("chat_bits", falla_bits_o, 3'b001);
    check("chat_or", falla_o, 1);
    check("chat_sens", sensores_o, 3'b111);
    repeat (VEN) tick();
    check("chat_clear", falla_bits_o, 3'b000);

    repeat (5) tick();
    raw = 3'b100;
    tick();
    raw = 3'b101;
    repeat (3) tick();
    #2 rst_i = 1'b0;
    #1;
    check("mid_rst_sens", sensores_o, 3'b111);
    check("mid_rst_cambio", cambio_o, 0);
    check("mid_rst_falla", falla_bits_o, 3'b000);
    repeat (2) begin
      @(posedge ck);
      #1;
      check("mid_rst_hold", sensores_o, 3'b111);
    end
    rst_i = 1'b1;
    restart_model();
    push_at(DEB + 2, 3'b101);
    run_to(10);
    drive(3'b100);
    run_to(20);
    drive(3'b101);
    run_to(29);
    drive(3'b100);
    run_to(32);
    check("close_w0_bits", falla_bits_o, 3'b001);
    check("close_w0_or", falla_o, 1);
    run_to(40);
    drive(3'b101);
    run_to(50);
    drive(3'b100);
    run_to(64);
    check("close_w1_bits", falla_bits_o, 3'b000);
    check("close_w1_or", falla_o, 0);
    run_to(70);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filtro_sensores.md
# filtro_sensores

Input conditioning stage for the pump controller. It synchronises the three raw level-sensor lines (two for the upper tank, one for the cistern) and debounces each line independently. The resulting clean `sensores_o[2:0]` vector drives the controller's `sensores_i` input directly. It also flags sensors that chatter, so that a failing float switch is reported rather than turning into random pump cycling.

## Interface
- `DEBOUNCE`, 16: consecutive stable cycles required before a filtered bit changes; legal range 1..65535.
- `VENTANA`, 1024: length in cycles of the chatter-observation window; must be ≥ 2.
- `MAX_CAMBIOS`, 8: per-bit transition count within one window that declares a fault; must be ≥ 1.
- `SENS_RESET`, 3'b111: reset value of the synchroniser, filtered and delayed registers.

Ports:
- `ck` in 1: single clock for the block.
- `rst_i` in 1: asynchronous, active-low reset.
- `sensores_raw_i` in 3: raw sensor lines, asynchronous to `ck`.
- `sensores_o` out 3: debounced sensor vector; feeds the pump controller.
- `cambio_o` out 1: one-cycle pulse that marks an update of `sensores_o`.
- `falla_bits_o` out 3: per-bit chatter flag from the last completed window.
- `falla_o` out 1: OR of `falla_bits_o`.

## Operation
- **Synchroniser.** Each bit passes through a two-flop chain `s1 → s2`. A third flop `s3` holds `s2` delayed by one cycle, for edge detection.
- **Debounce, per bit i.** Counter `cnt[i]` has width `max(1, $clog2(DEBOUNCE))`.
  - While `s2[i] == filt[i]`: `cnt[i] <= 0`.
  - While `s2[i] != filt[i]` and `cnt[i] < DEBOUNCE-1`: `cnt[i] <= cnt[i]+1`.
  - While `s2[i] != filt[i]` and `cnt[i] == DEBOUNCE-1`: `filt[i] <= s2[i]` and `cnt[i] <= 0`.
  - A mismatch that ends early (a bounce back) discards all progress.
  - `DEBOUNCE = 1` makes `filt` follow `s2` one cycle late.
- **Output.** `sensores_o = filt`, registered. `cambio_o` is registered and asserted in the same cycle the new `filt` value becomes visible. When several bits update on the same edge, `cambio_o` is a single pulse.
- **Chatter monitor.**
  - Window counter `win` runs 0..`VENTANA-1` and wraps.
  - Per-bit transition counter `tr[i]` increments when `s2[i] != s3[i]`. It saturates at `MAX_CAMBIOS`.
  - On the cycle with `win == VENTANA-1`:
    - `falla_bits_o[i] <= (tr[i] + edge_this_cycle[i] >= MAX_CAMBIOS)`, computed with the saturated sum.
    - All `tr` are cleared. A transition on this cycle counts only in the closing window.
  - `falla_bits_o` holds its value for a full window. It clears at the end of the first window in which that bit stays below threshold.
  - Chatter does not block debouncing; `sensores_o` keeps following stable levels.
- **Reset.** Asynchronous assert, any time, including mid-debounce or mid-window. All state returns immediately to the reset values below, and no `cambio_o` pulse is produced by reset.

## Timing
- Reset values:
  - `s1`, `s2`, `s3`, `filt`, `sensores_o` = `SENS_RESET`.
  - `cnt`, `tr`, `win` = 0.
  - `cambio_o`, `falla_bits_o`, `falla_o` = 0.
- Latency:
  - A raw level first sampled at edge k, and held, appears on `sensores_o` after edge k+`DEBOUNCE`+1, with `cambio_o` high for exactly that cycle.
  - Minimum latency is 3 edges (for `DEBOUNCE = 1`).
- Glitch rejection: a raw pulse shorter than `DEBOUNCE` cycles at `s2` never reaches `sensores_o`.
- Fault flag update: `falla_o` changes only on the edge that closes a window, every `VENTANA` cycles after reset release. It is derived combinationally from the registered `falla_bits_o`, so it carries no extra latency.
- Counter widths: `tr` uses `$clog2(MAX_CAMBIOS+1)` bits, and `win` uses `$clog2(VENTANA)` bits. No counter may wrap unintentionally.

## Test plan
All scenarios use bench parameters `DEBOUNCE=4`, `VENTANA=32`, `MAX_CAMBIOS=3`, `SENS_RESET=3'b111`.
- **Reset.** Hold `rst_i=0` with raw 3'b000 → `sensores_o=3'b111`, `cambio_o=0`, `falla_o=0`. Release → no pulse until the debounce expires.
- **Clean step.** Raw 3'b111→3'b011 at edge k, held → `sensores_o=3'b011` after edge k+5, `cambio_o` high for 1 cycle, `falla_o` still 0.
- **Glitch.** Raw bit2 low for 3 cycles then back high → `sensores_o` stays 3'b111, no `cambio_o`. A 4-cycle glitch does update the output.
- **Simultaneous change.** Raw 3'b111→3'b001 (two bits together) → one `cambio_o` pulse, `sensores_o=3'b001` after 5 edges.
- **Chatter.** Toggle raw bit0 every 2 cycles for one window → at window close `falla_bits_o=3'b001`, `falla_o=1`. Then hold steady → cleared at the close of the next window.
- **Reset mid-operation.** Assert `rst_i` with `cnt[1]=2` and `tr[0]=2` → `sensores_o=3'b111` and all counters 0 immediately. After release, a transition on window-close cycle 31 counts only toward the closing window.
